// File: rtl/bus_sync_tx.sv
// Transmit-side buffer feeding a pulse-handshake bus synchronizer: FIFO + launch/hold FSM.
// Optional ack timeout is enabled by defining BUS_SYNC_TX_TIMEOUT_EN.
module bus_sync_tx #(
    parameter int DWIDTH      = 32,
    parameter int DEPTH       = 4,
    parameter int HOLD_CYC    = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                     i_clk,
    input  logic                     rst_n,
    input  logic [DWIDTH-1:0]        i_data,
    input  logic                     i_valid,
    output logic                     o_ready,
    output logic [DWIDTH-1:0]        o_sync_data,
    output logic                     o_sync_valid,
    input  logic                     i_sync_ready,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_busy
`ifdef BUS_SYNC_TX_TIMEOUT_EN
    ,
    output logic                     o_timeout_err
`endif
);

    localparam int PW  = $clog2(DEPTH);
    localparam int LW  = PW + 1;
    localparam int HCW = $clog2(HOLD_CYC + 1);
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LAUNCH    = 3'd1;
    localparam logic [2:0] S_WAIT_LOW  = 3'd2;
    localparam logic [2:0] S_WAIT_HIGH = 3'd3;
    localparam logic [2:0] S_HOLD      = 3'd4;

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("bus_sync_tx: DEPTH must be a power of two >= 2");
        end
        if (HOLD_CYC < 1) begin : g_bad_hold
            $error("bus_sync_tx: HOLD_CYC must be >= 1");
        end
        if (TIMEOUT_CYC < 1) begin : g_bad_tmo
            $error("bus_sync_tx: TIMEOUT_CYC must be >= 1");
        end
    endgenerate

    logic [DWIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic [2:0]        state_q, state_d;
    logic [HCW-1:0]    hold_cnt_q, hold_cnt_d;
    logic [DWIDTH-1:0] sync_data_q, sync_data_d;
    logic              sync_valid_q;
    logic              push, pop;

    assign o_ready      = (level_q < DEPTH_L);
    assign o_level      = level_q;
    assign o_busy       = (state_q != S_IDLE);
    assign o_sync_data  = sync_data_q;
    assign o_sync_valid = sync_valid_q;

    assign push = i_valid && o_ready;

`ifdef BUS_SYNC_TX_TIMEOUT_EN
    localparam int TCW = $clog2(TIMEOUT_CYC + 1);
    logic [TCW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic           tmo_err_q, tmo_err_d;
    logic           in_wait, tmo_hit;

    assign in_wait       = (state_q == S_WAIT_LOW) || (state_q == S_WAIT_HIGH);
    // Counter value TIMEOUT_CYC-1 means this is the TIMEOUT_CYC-th waiting cycle.
    assign tmo_hit       = in_wait && (tmo_cnt_q == TCW'(TIMEOUT_CYC - 1));
    assign o_timeout_err = tmo_err_q;
`endif

    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        sync_data_d = sync_data_q;
        pop         = 1'b0;
`ifdef BUS_SYNC_TX_TIMEOUT_EN
        tmo_cnt_d   = in_wait ? tmo_cnt_q + TCW'(1) : '0;
        tmo_err_d   = tmo_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (level_q != '0 && i_sync_ready) begin
                    pop         = 1'b1;
                    sync_data_d = mem_q[rd_ptr_q];
                    state_d     = S_LAUNCH;
                end
            end
            S_LAUNCH: state_d = S_WAIT_LOW;
            S_WAIT_LOW: begin
                if (!i_sync_ready) begin
                    state_d = S_WAIT_HIGH;
                end
`ifdef BUS_SYNC_TX_TIMEOUT_EN
                else if (tmo_hit) begin
                    state_d   = S_IDLE;
                    tmo_err_d = 1'b1;
                end
`endif
            end
            S_WAIT_HIGH: begin
                if (i_sync_ready) begin
                    state_d    = S_HOLD;
                    hold_cnt_d = '0;
                end
`ifdef BUS_SYNC_TX_TIMEOUT_EN
                else if (tmo_hit) begin
                    state_d   = S_IDLE;
                    tmo_err_d = 1'b1;
                end
`endif
            end
            S_HOLD: begin
                if (hold_cnt_q == HCW'(HOLD_CYC - 1)) begin
                    state_d    = S_IDLE;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HCW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        level_d  = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Storage is left unreset; the pointers and level define which entries are live.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            state_q      <= S_IDLE;
            hold_cnt_q   <= '0;
            sync_data_q  <= '0;
            sync_valid_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            sync_data_q  <= sync_data_d;
            sync_valid_q <= (state_d == S_LAUNCH);
        end
    end

`ifdef BUS_SYNC_TX_TIMEOUT_EN
    always_ff @(posedge i_clk) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            tmo_err_q <= tmo_err_d;
        end
    end
`endif

endmodule

// File: doc/bus_sync_tx.md
BUS_SYNC_TX -- requirements
Module: bus_sync_tx

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, data width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, buffer entries; power of two, >=2.
REQ-003 SHALL have parameter HOLD_CYC, default 2, cycles o_sync_data stays stable after handshake completes; >=1.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 64, ack timeout in cycles; used only under REQ-027.
REQ-005 SHALL have port i_clk  input  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port i_data  input  DWIDTH  upstream write data.
REQ-008 SHALL have port i_valid  input  1  upstream word valid.
REQ-009 SHALL have port o_ready  output  1  buffer can accept a word.
REQ-010 SHALL have port o_sync_data  output  DWIDTH  word presented to the pulse-handshake bus synchronizer.
REQ-011 SHALL have port o_sync_valid  output  1  single-cycle launch pulse to the synchronizer.
REQ-012 SHALL have port i_sync_ready  input  1  synchronizer ready; high when idle, low while a transfer is in flight.
REQ-013 SHALL have port o_level  output  $clog2(DEPTH)+1  buffer occupancy.
REQ-014 SHALL have port o_busy  output  1  high in any state other than IDLE.

Function
REQ-015 SHALL accept a word on a rising edge where i_valid=1 and o_ready=1; o_ready = (o_level < DEPTH), combinational from registered level.
REQ-016 SHALL implement a FIFO with pointers that wrap modulo DEPTH; order preserved; no word dropped or duplicated.
REQ-017 SHALL use FSM states IDLE, LAUNCH, WAIT_LOW, WAIT_HIGH, HOLD.
REQ-018 In IDLE with o_level>0 and i_sync_ready=1, the FSM SHALL pop the head word into o_sync_data and go to LAUNCH. Otherwise it SHALL remain in IDLE.
REQ-019 In LAUNCH, o_sync_valid SHALL be 1 for exactly this one cycle; the FSM SHALL then go to WAIT_LOW. o_sync_valid SHALL be 0 in all other states.
REQ-020 WAIT_LOW SHALL go to WAIT_HIGH when i_sync_ready=0. WAIT_HIGH SHALL go to HOLD when i_sync_ready=1.
REQ-021 HOLD SHALL last exactly HOLD_CYC cycles, then return to IDLE.
REQ-022 o_sync_data SHALL change only on the IDLE->LAUNCH edge, and SHALL be stable from LAUNCH through the last HOLD cycle.
REQ-023 Latency: a word accepted into an empty buffer while IDLE and i_sync_ready=1 SHALL produce o_sync_valid=1 in the 2nd cycle after the accepting edge.
REQ-024 A push and a pop on the same edge SHALL leave o_level unchanged. A push when full SHALL be impossible because o_ready=0.
REQ-025 Minimum launch spacing SHALL be 4+HOLD_CYC cycles. Back-to-back words SHALL still be launched one per handshake.

Reset
REQ-026 On a rising edge with rst_n=0, the block SHALL set o_level=0, both pointers=0, state=IDLE, o_sync_data=0, o_sync_valid=0, o_busy=0, counters=0 and o_timeout_err=0. A reset mid-transfer SHALL discard all buffered and in-flight words. o_ready SHALL be 1 on the first cycle after reset.

Configuration
REQ-027 The macro BUS_SYNC_TX_TIMEOUT_EN SHALL control the timeout feature.
- Defined: the block SHALL add output o_timeout_err (1 bit, sticky, cleared only by reset). A counter SHALL run across WAIT_LOW and WAIT_HIGH. If it reaches TIMEOUT_CYC, o_timeout_err SHALL be set, the in-flight word SHALL be dropped, and the FSM SHALL go to IDLE.
- Undefined: the port and counter SHALL be absent, and the FSM SHALL wait indefinitely.

Verification
REQ-028 Single word: push 0xA5A5_0001 into an empty buffer with i_sync_ready=1, and emulate the synchronizer (ready low 2 cycles after the pulse, high 6 cycles later). Required response: o_sync_valid is high for 1 cycle, 2 cycles after the push; data is stable until HOLD ends.
REQ-029 Fill: push 6 words with i_sync_ready held 0. Required response: o_ready drops after the 4th word, o_level=4, and no pulse occurs. Then release ready: 4 pulses occur in order, each followed by a handshake.
REQ-030 Simultaneous events: push a word on the same edge as the IDLE->LAUNCH pop while o_level=2. Required response: o_level remains 2.
REQ-031 Reset mid-transfer: assert rst_n=0 in WAIT_HIGH with o_level=3. Required response: the next cycle shows o_level=0, o_sync_valid=0, o_busy=0, o_sync_data=0.
REQ-032 With BUS_SYNC_TX_TIMEOUT_EN defined and TIMEOUT_CYC=8: keep i_sync_ready=1 after launch. Required response: o_timeout_err=1 after 8 cycles in WAIT_LOW, the FSM returns to IDLE, and the next word launches normally.
